cnn_out_addr_seq: RTL and testbench

//  Generates write-back addresses for post-activation / pooling results of the systolic array.

---
 rtl/cnn_out_addr_seq.sv | 206 ++++++++++++++++++++
 tb/tb_cnn_out_addr_seq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_out_addr_seq.sv
`default_nettype none
// ============================================================================
// Module      : cnn_out_addr_seq
// Description : Write-back address sequencer for pooled/activated results of
//               the systolic array. For every accepted activation beat it
//               issues one registered tuple (RAM select, row, channel group)
//               toward the output feature RAM bank. A start pulse latches the
//               run configuration; done pulses once the last beat is taken.
//               Optional sticky protocol-error flag: define OUT_SEQ_ERR_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_out_addr_seq #(
   parameter int COLS    = 4,
   parameter int ADDR_DW = 5,
   parameter int CH_DW   = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [ADDR_DW-1:0] cfg_cols,
   input  logic [ADDR_DW-1:0] cfg_win_step,
   input  logic [ADDR_DW-1:0] cfg_base_last,
   input  logic [CH_DW-1:0]   cfg_ch_last,
   input  logic               in_valid,
   input  logic               in_pool,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_DW-1:0] out_ram_sel,
   output logic [ADDR_DW-1:0] out_row,
   output logic [CH_DW-1:0]   out_ch,
   output logic               busy,
`ifdef OUT_SEQ_ERR_CHK_EN
   output logic               err_sticky,
`endif
   output logic               done
);

   localparam logic [ADDR_DW-1:0] C_ADDR_ONE = ADDR_DW'(1);
   localparam logic [CH_DW-1:0]   C_CH_STEP  = CH_DW'(COLS);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e             state_q;
   logic               done_q;

   // Run configuration, frozen for the whole run
   logic [ADDR_DW-1:0] cols_q;
   logic [ADDR_DW-1:0] step_q;
   logic [ADDR_DW-1:0] blast_q;
   logic [CH_DW-1:0]   chlast_q;

   // Position counters and their next values
   logic [ADDR_DW-1:0] x_q, x_d;
   logic [ADDR_DW-1:0] y_q, y_d;
   logic [ADDR_DW-1:0] base_q, base_d;
   logic [CH_DW-1:0]   ch_q, ch_d;

   // Single output register stage
   logic               out_valid_q;
   logic [ADDR_DW-1:0] sel_q;
   logic [ADDR_DW-1:0] row_q;
   logic [CH_DW-1:0]   och_q;

   logic               w_busy;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_row_wrap;
   logic               w_base_wrap;
   logic               w_final;
   logic               w_start_idle;

   assign w_busy       = (state_q == ST_RUN);
   // Output slot is free when empty or being emptied this cycle (no skid buffer)
   assign w_in_ready   = w_busy & (~out_valid_q | out_ready);
   assign w_accept     = in_valid & w_in_ready;
   assign w_start_idle = start & ~w_busy;
   assign w_row_wrap   = ~in_pool & (x_q == (cols_q - C_ADDR_ONE));
   assign w_base_wrap  = w_row_wrap & (base_q == blast_q);
   assign w_final      = w_base_wrap & (ch_q == chlast_q);

   // Counter advance for an accepted beat; nested wraps x -> base -> ch
   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      base_d = base_q;
      ch_d   = ch_q;
      if (w_accept) begin
         if (in_pool) begin
            y_d = y_q + C_ADDR_ONE;
         end else begin
            y_d = '0;
            if (w_row_wrap) begin
               x_d = '0;
               if (base_q == blast_q) begin
                  base_d = '0;
                  ch_d   = (ch_q == chlast_q) ? '0 : (ch_q + C_CH_STEP);
               end else begin
                  base_d = base_q + step_q;
               end
            end else begin
               x_d = x_q + C_ADDR_ONE;
            end
         end
      end
   end

   // Run-control FSM: config latch on start, done pulse after the final beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         done_q   <= 1'b0;
         cols_q   <= '0;
         step_q   <= '0;
         blast_q  <= '0;
         chlast_q <= '0;
      end else begin
         done_q <= w_accept & w_final;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q  <= ST_RUN;
                  cols_q   <= cfg_cols;
                  step_q   <= cfg_win_step;
                  blast_q  <= cfg_base_last;
                  chlast_q <= cfg_ch_last;
               end
            end
            ST_RUN: begin
               if (w_accept && w_final) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Position counters; a fresh run always starts from the origin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q    <= '0;
         y_q    <= '0;
         base_q <= '0;
         ch_q   <= '0;
      end else if (w_start_idle) begin
         x_q    <= '0;
         y_q    <= '0;
         base_q <= '0;
         ch_q   <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         base_q <= base_d;
         ch_q   <= ch_d;
      end
   end

   // Output tuple register: load on accept, hold while stalled, drop when drained
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sel_q       <= '0;
         row_q       <= '0;
         och_q       <= '0;
      end else if (w_accept) begin
         out_valid_q <= 1'b1;
         sel_q       <= base_q + y_q;
         row_q       <= x_q;
         och_q       <= ch_q;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

`ifdef OUT_SEQ_ERR_CHK_EN
   logic err_q;

   // Sticky flag for beats offered while idle or a y overflow inside a window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (w_start_idle) begin
         err_q <= 1'b0;
      end else if ((in_valid && !w_busy) || (w_accept && in_pool && (y_q == '1))) begin
         err_q <= 1'b1;
      end
   end

   assign err_sticky = err_q;
`endif

   assign in_ready    = w_in_ready;
   assign out_valid   = out_valid_q;
   assign out_ram_sel = sel_q;
   assign out_row     = row_q;
   assign out_ch      = och_q;
   assign busy        = w_busy;
   assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_cnn_out_addr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_out_addr_seq
// Description : Self-checking bench for cnn_out_addr_seq. Expected tuples are
//               generated by walking channel / base / row / window loops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_out_addr_seq;

   localparam int COLS    = 4;
   localparam int ADDR_DW = 5;
   localparam int CH_DW   = 6;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic [ADDR_DW-1:0] cfg_cols;
   logic [ADDR_DW-1:0] cfg_win_step;
   logic [ADDR_DW-1:0] cfg_base_last;
   logic [CH_DW-1:0]   cfg_ch_last;
   logic               in_valid;
   logic               in_pool;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready;
   logic [ADDR_DW-1:0] out_ram_sel;
   logic [ADDR_DW-1:0] out_row;
   logic [CH_DW-1:0]   out_ch;
   logic               busy;
   logic               done;
`ifdef OUT_SEQ_ERR_CHK_EN
   logic               err_sticky;
`endif

   int tests = 0;
   int fails = 0;

   // Stimulus beats (in_pool values) and expected tuples, in order
   bit                 beats[$];
   logic [ADDR_DW-1:0] exp_sel[$];
   logic [ADDR_DW-1:0] exp_row[$];
   logic [CH_DW-1:0]   exp_ch[$];

   always #5 clk = ~clk;

   cnn_out_addr_seq #(.COLS(COLS), .ADDR_DW(ADDR_DW), .CH_DW(CH_DW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .cfg_cols      (cfg_cols),
      .cfg_win_step  (cfg_win_step),
      .cfg_base_last (cfg_base_last),
      .cfg_ch_last   (cfg_ch_last),
      .in_valid      (in_valid),
      .in_pool       (in_pool),
      .in_ready      (in_ready),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_ram_sel   (out_ram_sel),
      .out_row       (out_row),
      .out_ch        (out_ch),
      .busy          (busy),
`ifdef OUT_SEQ_ERR_CHK_EN
      .err_sticky    (err_sticky),
`endif
      .done          (done)
   );

   function automatic void clear_model();
      beats.delete();
      exp_sel.delete();
      exp_row.delete();
      exp_ch.delete();
   endfunction

   function automatic void push_exp(input int sel, input int row, input int ch);
      exp_sel.push_back(ADDR_DW'(sel));
      exp_row.push_back(ADDR_DW'(row));
      exp_ch.push_back(CH_DW'(ch));
   endfunction

   // Reference: for each channel group, each base, each output column, one
   // window of L pooling beats followed by a closing beat; address = base + k.
   function automatic void build_model(input int cols, input int step, input int nb,
                                       input int nc, input int max_len);
      clear_model();
      for (int c = 0; c <= nc; c++)
         for (int b = 0; b <= nb; b++)
            for (int x = 0; x < cols; x++) begin
               int len;
               len = $urandom_range(0, max_len);
               for (int k = 0; k <= len; k++) begin
                  beats.push_back(k < len);
                  push_exp((b * step + k) % 32, x, c * COLS);
               end
            end
   endfunction

   task automatic do_start(input int cols, input int step, input int blast, input int chlast);
      @(negedge clk);
      cfg_cols      = ADDR_DW'(cols);
      cfg_win_step  = ADDR_DW'(step);
      cfg_base_last = ADDR_DW'(blast);
      cfg_ch_last   = CH_DW'(chlast);
      start         = 1'b1;
      @(negedge clk);
      start         = 1'b0;
      // Scramble cfg inputs: the run must use the latched copy
      cfg_cols      = ADDR_DW'($urandom);
      cfg_win_step  = ADDR_DW'($urandom);
      cfg_base_last = ADDR_DW'($urandom);
      cfg_ch_last   = CH_DW'($urandom);
      #1;
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL start_busy: busy=%0b expected 1", busy);
      end
   endtask

   // Drive the beat queue, consume and check the output stream.
   // ready_mode: 0 always ready, 1 random, 2 stall 3 cycles after first accept
   task automatic run_stream(input int valid_pct, input int ready_mode);
      int                 sent, cyc, stall_left, total;
      bit                 exp_done, seen_done, acc, oh, hold_v, first_acc, prev_acc;
      logic [ADDR_DW-1:0] h_sel, h_row, f_sel, f_row;
      logic [CH_DW-1:0]   h_ch, f_ch;
      sent = 0; cyc = 0; stall_left = 0; total = beats.size();
      exp_done = 0; seen_done = 0; hold_v = 0; first_acc = 1; prev_acc = 0;
      h_sel = '0; h_row = '0; h_ch = '0;
      f_sel = exp_sel[exp_sel.size()-1];
      f_row = exp_row[exp_row.size()-1];
      f_ch  = exp_ch[exp_ch.size()-1];
      while (!(seen_done && exp_sel.size() == 0) && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         in_valid = (sent < total) && ($urandom_range(1, 100) <= valid_pct);
         in_pool  = (sent < total) ? beats[sent] : 1'b0;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = $urandom_range(0, 1);
            default: begin
               out_ready = (stall_left == 0);
               if (stall_left > 0) stall_left--;
            end
         endcase
         #1;
         tests++;
         if (done !== exp_done) begin
            fails++;
            $display("FAIL done_timing: done=%0b expected %0b (beat %0d)", done, exp_done, sent);
         end
         if (exp_done) begin
            tests++;
            if (out_valid !== 1'b1 || busy !== 1'b0 || out_ram_sel !== f_sel ||
                out_row !== f_row || out_ch !== f_ch) begin
               fails++;
               $display("FAIL done_tuple: v=%0b busy=%0b (%0d,%0d,%0d) expected v=1 busy=0 (%0d,%0d,%0d)",
                        out_valid, busy, out_ram_sel, out_row, out_ch, f_sel, f_row, f_ch);
            end
         end
         if (done) seen_done = 1;
         if (prev_acc) begin
            tests++;
            if (out_valid !== 1'b1) begin
               fails++;
               $display("FAIL latency: out_valid=%0b expected 1 after accept", out_valid);
            end
         end
         if (hold_v) begin
            tests++;
            if (out_valid !== 1'b1 || out_ram_sel !== h_sel || out_row !== h_row || out_ch !== h_ch) begin
               fails++;
               $display("FAIL hold_stable: v=%0b (%0d,%0d,%0d) expected v=1 (%0d,%0d,%0d)",
                        out_valid, out_ram_sel, out_row, out_ch, h_sel, h_row, h_ch);
            end
         end
         if (out_valid && !out_ready) begin
            tests++;
            if (in_ready !== 1'b0) begin
               fails++;
               $display("FAIL stall_in_ready: in_ready=%0b expected 0", in_ready);
            end
         end
         acc = in_valid && in_ready;
         oh  = out_valid && out_ready;
         if (oh) begin
            tests++;
            if (exp_sel.size() == 0) begin
               fails++;
               $display("FAIL extra_tuple: got (%0d,%0d,%0d) expected none", out_ram_sel, out_row, out_ch);
            end else begin
               if (out_ram_sel !== exp_sel[0] || out_row !== exp_row[0] || out_ch !== exp_ch[0]) begin
                  fails++;
                  $display("FAIL tuple: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                           out_ram_sel, out_row, out_ch, exp_sel[0], exp_row[0], exp_ch[0]);
               end
               void'(exp_sel.pop_front());
               void'(exp_row.pop_front());
               void'(exp_ch.pop_front());
            end
         end
         hold_v = out_valid && !out_ready;
         h_sel = out_ram_sel; h_row = out_row; h_ch = out_ch;
         exp_done = acc && (sent == total - 1);
         prev_acc = acc;
         if (acc) begin
            sent++;
            if (first_acc && ready_mode == 2) stall_left = 3;
            first_acc = 0;
         end
      end
      tests++;
      if (cyc >= 4000) begin
         fails++;
         $display("FAIL stream_timeout: sent %0d of %0d, %0d tuples left", sent, total, exp_sel.size());
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pool = 1'b0; out_ready = 1'b1;
      cfg_cols = '0; cfg_win_step = '0; cfg_base_last = '0; cfg_ch_last = '0;
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if (out_valid !== 0 || busy !== 0 || in_ready !== 0 || done !== 0 ||
          out_ram_sel !== 0 || out_row !== 0 || out_ch !== 0) begin
         fails++;
         $display("FAIL reset_state: v=%0b busy=%0b rdy=%0b done=%0b (%0d,%0d,%0d) expected all 0",
                  out_valid, busy, in_ready, done, out_ram_sel, out_row, out_ch);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_start(2, 2, 2, 4);
      out_ready = 1'b0;
      @(negedge clk); in_valid = 1'b1; in_pool = 1'b0;
      @(negedge clk); in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 0 || busy !== 0 || in_ready !== 0 || done !== 0 ||
          out_ram_sel !== 0 || out_row !== 0 || out_ch !== 0) begin
         fails++;
         $display("FAIL reset_midrun: v=%0b busy=%0b rdy=%0b done=%0b (%0d,%0d,%0d) expected all 0",
                  out_valid, busy, in_ready, done, out_ram_sel, out_row, out_ch);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int sels[8];
      sels = '{0, 1, 0, 1, 2, 3, 2, 3};
      clear_model();
      for (int c = 0; c < 2; c++)
         for (int i = 0; i < 8; i++) begin
            beats.push_back((i % 2) == 0);
            push_exp(sels[i], (i / 2) % 2, c * 4);
         end
      do_start(2, 2, 2, 4);
      run_stream(100, 0);
   endtask

   task automatic test_backpressure();
      build_model(2, 2, 1, 1, 3);
      do_start(2, 2, 2, 4);
      run_stream(100, 2);
   endtask

   task automatic test_wrap();
      clear_model();
      beats.push_back(1'b0);
      push_exp(0, 0, 0);
      do_start(1, 3, 0, 0);
      run_stream(100, 0);
      #1;
      tests++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL wrap_idle: busy=%0b in_ready=%0b expected 0 0", busy, in_ready);
      end
   endtask

   task automatic test_start_in_done();
      do_start(1, 1, 0, 0);
      @(negedge clk);
      in_valid = 1'b1; in_pool = 1'b0; out_ready = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL sid_ready: in_ready=%0b expected 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      start = 1'b1;
      cfg_cols = 1; cfg_win_step = 1; cfg_base_last = 0; cfg_ch_last = 0;
      #1;
      tests++;
      if (done !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b0 ||
          out_ram_sel !== 0 || out_row !== 0 || out_ch !== 0) begin
         fails++;
         $display("FAIL sid_done: done=%0b v=%0b busy=%0b (%0d,%0d,%0d) expected 1 1 0 (0,0,0)",
                  done, out_valid, busy, out_ram_sel, out_row, out_ch);
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      tests++;
      if (busy !== 1'b1 || done !== 1'b0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL sid_restart: busy=%0b done=%0b v=%0b expected 1 0 0", busy, done, out_valid);
      end
      clear_model();
      beats.push_back(1'b0);
      push_exp(0, 0, 0);
      run_stream(100, 0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         int cols, step, nb, nc;
         cols = $urandom_range(1, 3);
         step = $urandom_range(1, 14);
         nb   = $urandom_range(0, 2);
         nc   = $urandom_range(0, 2);
         build_model(cols, step, nb, nc, 5);
         do_start(cols, step, nb * step, nc * COLS);
         run_stream($urandom_range(40, 100), 1);
      end
   endtask

`ifdef OUT_SEQ_ERR_CHK_EN
   task automatic test_err();
      @(negedge clk);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      tests++;
      if (err_sticky !== 1'b1) begin
         fails++;
         $display("FAIL err_set: err_sticky=%0b expected 1", err_sticky);
      end
      do_start(1, 1, 0, 0);
      tests++;
      if (err_sticky !== 1'b0) begin
         fails++;
         $display("FAIL err_clear: err_sticky=%0b expected 0", err_sticky);
      end
      clear_model();
      beats.push_back(1'b0);
      push_exp(0, 0, 0);
      run_stream(100, 0);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_start_in_done();
      test_random();
`ifdef OUT_SEQ_ERR_CHK_EN
      test_err();
`endif
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
